// File: rtl/wb_arb_pkg.sv
`default_nettype none
// =============================================================================
// wb_arb_pkg: shared state encoding and constants for the Wishbone bus arbiter.
// Revision 1.0
// =============================================================================
package wb_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY    = 2'd1,
      ARB_TIMEOUT = 2'd2
   } arb_state_t;

   localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/wb_rr_picker.sv
`default_nettype none
// =============================================================================
// wb_rr_picker: combinational round-robin select, first request at/after rr_ptr.
// Revision 1.0
// =============================================================================
module wb_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner_oh,
   output logic [IDX_W-1:0]   winner_idx,
   output logic               valid
);

   always_comb begin
      int cand;
      cand       = 0;
      winner_oh  = '0;
      winner_idx = '0;
      valid      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(rr_ptr) + i) % NUM_REQ;
         if (!valid && req[cand]) begin
            valid           = 1'b1;
            winner_idx      = cand[IDX_W-1:0];
            winner_oh[cand] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// =============================================================================
// wb_bus_arbiter: round-robin arbiter sharing one Wishbone port; grant held per cyc tenure.
// Optional ack watchdog enabled by macro WB_ARB_TIMEOUT_EN.  Revision 1.0
// =============================================================================
module wb_bus_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                            wb_clk_i,
   input  logic                            rst_i,
   input  logic [NUM_MASTERS-1:0]          m_cyc_i,
   input  logic [NUM_MASTERS-1:0]          m_stb_i,
   input  logic [NUM_MASTERS-1:0]          m_we_i,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
   input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
   input  logic [NUM_MASTERS*DATA_W/8-1:0] m_sel_i,
   output logic [NUM_MASTERS-1:0]          m_ack_o,
   output logic [DATA_W-1:0]               m_rdata_o,
   output logic                            s_cyc_o,
   output logic                            s_stb_o,
   output logic                            s_we_o,
   output logic [ADDR_W-1:0]               s_addr_o,
   output logic [DATA_W-1:0]               s_wdata_o,
   output logic [DATA_W/8-1:0]             s_sel_o,
   input  logic                            s_ack_i,
   input  logic [DATA_W-1:0]               s_rdata_i,
   output logic [NUM_MASTERS-1:0]          grant_o
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SEL_W = DATA_W / 8;

   arb_state_t             state, state_nxt;
   logic [NUM_MASTERS-1:0] grant, grant_nxt;
   logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;

   logic [NUM_MASTERS-1:0] pick_oh;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;

   logic                   gnt_cyc, gnt_stb, gnt_we;
   logic [ADDR_W-1:0]      gnt_addr;
   logic [DATA_W-1:0]      gnt_wdata;
   logic [SEL_W-1:0]       gnt_sel;

   wb_rr_picker #(
      .NUM_REQ (NUM_MASTERS),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req        (m_cyc_i),
      .rr_ptr     (rr_ptr),
      .winner_oh  (pick_oh),
      .winner_idx (pick_idx),
      .valid      (pick_valid)
   );

   // Grant is one-hot, so a plain select loop yields the owner's request.
   always_comb begin
      gnt_cyc   = 1'b0;
      gnt_stb   = 1'b0;
      gnt_we    = 1'b0;
      gnt_addr  = '0;
      gnt_wdata = '0;
      gnt_sel   = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (grant[k]) begin
            gnt_cyc   = m_cyc_i[k];
            gnt_stb   = m_stb_i[k];
            gnt_we    = m_we_i[k];
            gnt_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
            gnt_wdata = m_wdata_i[k*DATA_W +: DATA_W];
            gnt_sel   = m_sel_i[k*SEL_W +: SEL_W];
         end
      end
   end

   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_addr_o  = '0;
      s_wdata_o = '0;
      s_sel_o   = '0;
      m_ack_o   = '0;
      m_rdata_o = s_rdata_i;
      case (state)
         ARB_BUSY: begin
            s_cyc_o   = gnt_cyc;
            s_stb_o   = gnt_cyc & gnt_stb;
            s_we_o    = gnt_we;
            s_addr_o  = gnt_addr;
            s_wdata_o = gnt_wdata;
            s_sel_o   = gnt_sel;
            m_ack_o   = s_ack_i ? grant : '0;
         end
`ifdef WB_ARB_TIMEOUT_EN
         ARB_TIMEOUT: begin
            m_ack_o   = grant;
            m_rdata_o = DATA_W'(ARB_TIMEOUT_RDATA);
         end
`endif
         default: ;
      endcase
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             to_hit;

   // Watchdog fires on the cycle whose strobe would bring the count to the limit.
   assign to_hit = (state == ARB_BUSY) && s_stb_o && !s_ack_i &&
                   (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge wb_clk_i) begin
      if (rst_i || state != ARB_BUSY || s_ack_i) begin
         to_cnt <= '0;
      end else if (s_stb_o) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   logic to_hit;
   logic unused_timeout_cfg;
   assign to_hit             = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      rr_ptr_nxt = rr_ptr;
      case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_nxt  = ARB_BUSY;
               grant_nxt  = pick_oh;
               rr_ptr_nxt = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
            end
         end
         ARB_BUSY: begin
            if (!gnt_cyc) begin
               state_nxt = ARB_IDLE;
               grant_nxt = '0;
            end else if (to_hit) begin
               state_nxt = ARB_TIMEOUT;
            end
         end
         ARB_TIMEOUT: begin
            if (gnt_cyc) begin
               state_nxt = ARB_BUSY;
            end else begin
               state_nxt = ARB_IDLE;
               grant_nxt = '0;
            end
         end
         default: begin
            state_nxt = ARB_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst_i) begin
         state  <= ARB_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

   assign grant_o = grant;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// =============================================================================
// tb_wb_bus_arbiter: directed self-checking bench for wb_bus_arbiter (2 masters).
// Revision 1.0
// =============================================================================
module tb_wb_bus_arbiter;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM-1:0]    m_cyc, m_stb, m_we;
   logic [NM*AW-1:0] m_addr;
   logic [NM*DW-1:0] m_wdata;
   logic [NM*DW/8-1:0] m_sel;
   logic [NM-1:0]    m_ack;
   logic [DW-1:0]    m_rdata;
   logic             s_cyc, s_stb, s_we, s_ack;
   logic [AW-1:0]    s_addr;
   logic [DW-1:0]    s_wdata, s_rdata;
   logic [DW/8-1:0]  s_sel;
   logic [NM-1:0]    grant;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   wb_bus_arbiter #(
      .NUM_MASTERS    (NM),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .wb_clk_i  (clk),
      .rst_i     (rst),
      .m_cyc_i   (m_cyc),
      .m_stb_i   (m_stb),
      .m_we_i    (m_we),
      .m_addr_i  (m_addr),
      .m_wdata_i (m_wdata),
      .m_sel_i   (m_sel),
      .m_ack_o   (m_ack),
      .m_rdata_o (m_rdata),
      .s_cyc_o   (s_cyc),
      .s_stb_o   (s_stb),
      .s_we_o    (s_we),
      .s_addr_o  (s_addr),
      .s_wdata_o (s_wdata),
      .s_sel_o   (s_sel),
      .s_ack_i   (s_ack),
      .s_rdata_i (s_rdata),
      .grant_o   (grant)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      rst     = 1'b1;
      m_cyc   = '0;
      m_stb   = '0;
      m_we    = 2'b10;
      m_addr  = {32'h0000_0020, 32'h0000_0010};
      m_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
      m_sel   = {4'hF, 4'h3};
      s_ack   = 1'b0;
      s_rdata = 32'h1234_5678;
      tick();
      tick();

      // Reset state
      check("rst_grant", 64'(grant), 64'h0);
      check("rst_cyc",   64'(s_cyc), 64'h0);
      check("rst_ack",   64'(m_ack), 64'h0);
      check("rst_addr",  64'(s_addr), 64'h0);
      rst = 1'b0;

      // Single read by master 0
      m_cyc = 2'b01;
      m_stb = 2'b01;
      #1;
      check("req_not_yet_granted", 64'(s_cyc), 64'h0);
      tick();
      check("t1_grant", 64'(grant),  64'h1);
      check("t1_cyc",   64'(s_cyc),  64'h1);
      check("t1_stb",   64'(s_stb),  64'h1);
      check("t1_addr",  64'(s_addr), 64'h10);
      check("t1_we",    64'(s_we),   64'h0);
      check("t1_sel",   64'(s_sel),  64'h3);
      s_ack = 1'b1;
      #1;
      check("t1_ack",   64'(m_ack),   64'h1);
      check("t1_rdata", 64'(m_rdata), 64'h1234_5678);
      tick();
      s_ack = 1'b0;
      m_cyc = 2'b00;
      m_stb = 2'b00;
      tick();
      check("t1_release", 64'(grant), 64'h0);

      // Ack while idle is ignored
      s_ack = 1'b1;
      #1;
      check("idle_ack", 64'(m_ack), 64'h0);
      s_ack = 1'b0;

      // Both request: rr_ptr is 1, so grants go 10,01,10,01 with an idle gap
      w = 1;
      for (int t = 0; t < 4; t++) begin
         m_cyc = 2'b11;
         m_stb = 2'b11;
         tick();
         check("rr_grant", 64'(grant), 64'(1 << w));
         s_ack = 1'b1;
         #1;
         check("rr_ack", 64'(m_ack), 64'(1 << w));
         tick();
         s_ack = 1'b0;
         m_cyc = 2'(~(1 << w));
         m_stb = m_cyc;
         tick();
         check("rr_idle_gap", 64'(grant), 64'h0);
         w = 1 - w;
      end

      // Master 0 holds cyc for 3 transfers while master 1 waits
      m_cyc = 2'b01;
      m_stb = 2'b01;
      tick();
      check("hold_grant0", 64'(grant), 64'h1);
      m_cyc = 2'b11;
      m_stb = 2'b11;
      for (int t = 0; t < 3; t++) begin
         s_ack = 1'b1;
         #1;
         check("hold_ack0", 64'(m_ack), 64'h1);
         tick();
         s_ack = 1'b0;
         #1;
         check("hold_noack", 64'(m_ack), 64'h0);
         check("hold_keep", 64'(grant), 64'h1);
         tick();
      end
      m_cyc = 2'b10;
      m_stb = 2'b10;
      tick();
      check("hold_gap", 64'(grant), 64'h0);
      tick();
      check("m1_grant", 64'(grant),   64'h2);
      check("m1_addr",  64'(s_addr),  64'h20);
      check("m1_wdata", 64'(s_wdata), 64'hBBBB_0001);
      check("m1_we",    64'(s_we),    64'h1);
      check("m1_sel",   64'(s_sel),   64'hF);

      // Reset mid-tenure, then master 0 wins a simultaneous request
      rst = 1'b1;
      tick();
      check("midrst_cyc",   64'(s_cyc), 64'h0);
      check("midrst_grant", 64'(grant), 64'h0);
      m_cyc = 2'b11;
      m_stb = 2'b11;
      rst   = 1'b0;
      tick();
      check("postrst_grant", 64'(grant), 64'h1);

`ifdef WB_ARB_TIMEOUT_EN
      // No ack: watchdog answers after 4 strobe cycles
      m_cyc = 2'b01;
      m_stb = 2'b01;
      for (int t = 0; t < 3; t++) begin
         tick();
         check("to_wait_ack", 64'(m_ack), 64'h0);
         check("to_wait_cyc", 64'(s_cyc), 64'h1);
      end
      tick();
      check("to_ack",   64'(m_ack),   64'h1);
      check("to_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
      check("to_cyc",   64'(s_cyc),   64'h0);
      tick();
      check("to_resume_cyc", 64'(s_cyc), 64'h1);
      check("to_resume_ack", 64'(m_ack), 64'h0);
`else
      // No ack and no watchdog: bus stays owned
      m_cyc = 2'b01;
      m_stb = 2'b01;
      for (int t = 0; t < 6; t++) tick();
      check("hang_cyc",   64'(s_cyc), 64'h1);
      check("hang_ack",   64'(m_ack), 64'h0);
      check("hang_grant", 64'(grant), 64'h1);
`endif
      m_cyc = 2'b00;
      m_stb = 2'b00;
      tick();
      check("final_idle", 64'(grant), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
